alu_uart_interface: RTL and testbench

//  Byte-stream front end for the ALU, sitting between the UART RX/TX and the alu.
//  - Collects three received bytes in order: operand A, operand B, opcode.
//  - Drives them as stable registered inputs to the ALU.
//  - Captures the ALU result one cycle later and sends it back as one TX byte.

---
 rtl/alu_uart_interface_if.sv | 31 +++
 rtl/alu_uart_interface.sv | 124 ++++++++++++
 tb/tb_alu_uart_interface.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_uart_interface_if.sv
// Bundle of UART byte-stream and ALU operand/result signals for alu_uart_interface.
// slave is the front-end's view; master is the UART/ALU side.
interface alu_uart_interface_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_operation_code;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_alu_overflow;
    logic               i_alu_zero;
    logic               o_busy;

    modport slave (
        input  i_rx_data, i_rx_done, i_tx_done,
        input  i_alu_result, i_alu_overflow, i_alu_zero,
        output o_tx_data, o_tx_start, o_data_a, o_data_b, o_operation_code, o_busy
    );

    modport master (
        output i_rx_data, i_rx_done, i_tx_done,
        output i_alu_result, i_alu_overflow, i_alu_zero,
        input  o_tx_data, o_tx_start, o_data_a, o_data_b, o_operation_code, o_busy
    );
endinterface

// File: rtl/alu_uart_interface.sv
// Byte-stream front end for the ALU: gathers A, B, opcode from UART RX and returns the result on TX.
// Optional macro ALU_IF_FLAGS_EN appends a second TX byte carrying {0..., overflow, zero}.
module alu_uart_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    alu_uart_interface_if.slave  bus
);

`ifdef ALU_IF_FLAGS_EN
    typedef enum logic [2:0] {
        ST_WAIT_A   = 3'd0,
        ST_WAIT_B   = 3'd1,
        ST_WAIT_OP  = 3'd2,
        ST_COMPUTE  = 3'd3,
        ST_TX_RES   = 3'd4,
        ST_TX_FLG   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_WAIT_A   = 3'd0,
        ST_WAIT_B   = 3'd1,
        ST_WAIT_OP  = 3'd2,
        ST_COMPUTE  = 3'd3,
        ST_TX_RES   = 3'd4
    } state_t;
`endif

    state_t             state_q;
    logic [NB_DATA-1:0] data_a_q;
    logic [NB_DATA-1:0] data_b_q;
    logic [NB_OP-1:0]   op_code_q;
    logic [NB_DATA-1:0] tx_data_q;
    logic               tx_start_q;
    logic               busy_q;
`ifdef ALU_IF_FLAGS_EN
    logic               overflow_q;
    logic               zero_q;
`endif

    // Transaction FSM; every output is a register updated alongside the state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_WAIT_A;
            data_a_q   <= {NB_DATA{1'b0}};
            data_b_q   <= {NB_DATA{1'b0}};
            op_code_q  <= {NB_OP{1'b0}};
            tx_data_q  <= {NB_DATA{1'b0}};
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef ALU_IF_FLAGS_EN
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                ST_WAIT_A: begin
                    if (bus.i_rx_done) begin
                        data_a_q <= bus.i_rx_data;
                        state_q  <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (bus.i_rx_done) begin
                        data_b_q <= bus.i_rx_data;
                        state_q  <= ST_WAIT_OP;
                    end
                end
                ST_WAIT_OP: begin
                    if (bus.i_rx_done) begin
                        op_code_q <= bus.i_rx_data[NB_OP-1:0];
                        busy_q    <= 1'b1;
                        state_q   <= ST_COMPUTE;
                    end
                end
                // ALU inputs have been stable for a full cycle here, so its result is settled.
                ST_COMPUTE: begin
                    tx_data_q  <= bus.i_alu_result;
                    tx_start_q <= 1'b1;
`ifdef ALU_IF_FLAGS_EN
                    overflow_q <= bus.i_alu_overflow;
                    zero_q     <= bus.i_alu_zero;
`endif
                    state_q    <= ST_TX_RES;
                end
                ST_TX_RES: begin
                    if (bus.i_tx_done) begin
`ifdef ALU_IF_FLAGS_EN
                        tx_data_q  <= {{(NB_DATA-2){1'b0}}, overflow_q, zero_q};
                        tx_start_q <= 1'b1;
                        state_q    <= ST_TX_FLG;
`else
                        busy_q     <= 1'b0;
                        state_q    <= ST_WAIT_A;
`endif
                    end
                end
`ifdef ALU_IF_FLAGS_EN
                ST_TX_FLG: begin
                    if (bus.i_tx_done) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_WAIT_A;
                    end
                end
`endif
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_WAIT_A;
                end
            endcase
        end
    end

    assign bus.o_data_a         = data_a_q;
    assign bus.o_data_b         = data_b_q;
    assign bus.o_operation_code = op_code_q;
    assign bus.o_tx_data        = tx_data_q;
    assign bus.o_tx_start       = tx_start_q;
    assign bus.o_busy           = busy_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed plus randomized bench for alu_uart_interface with a bench-side ALU and reference model.
module tb_alu_uart_interface;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;

    alu_uart_interface_if #(.NB_DATA(8), .NB_OP(6)) bus ();

    alu_uart_interface #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: returns {zero, overflow(carry/borrow), result}.
    function automatic logic [9:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        logic [8:0] wide;
        logic [7:0] r;
        logic       c;
        wide = 9'd0;
        c    = 1'b0;
        case (op)
            6'h20:   begin wide = {1'b0, a} + {1'b0, b}; r = wide[7:0]; c = wide[8]; end
            6'h22:   begin r = a - b; c = (a < b); end
            6'h24:   r = a & b;
            6'h25:   r = a | b;
            6'h26:   r = a ^ b;
            6'h27:   r = ~(a | b);
            6'h02:   r = a >> 1;
            6'h03:   r = {a[7], a[7:1]};
            default: r = 8'h00;
        endcase
        return {(r == 8'h00), c, r};
    endfunction

    // Bench-side combinational ALU attached to the DUT operand outputs.
    always_comb begin
        logic [9:0] res;
        res = alu_ref(bus.o_data_a, bus.o_data_b, bus.o_operation_code);
        bus.i_alu_result   = res[7:0];
        bus.i_alu_overflow = res[8];
        bus.i_alu_zero     = res[9];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx_data"},  {8'h00, bus.o_tx_data}, 16'h0000);
        chk({tag, "_tx_start"}, {15'd0, bus.o_tx_start}, 16'h0000);
        chk({tag, "_data_a"},   {8'h00, bus.o_data_a}, 16'h0000);
        chk({tag, "_data_b"},   {8'h00, bus.o_data_b}, 16'h0000);
        chk({tag, "_opcode"},   {10'd0, bus.o_operation_code}, 16'h0000);
        chk({tag, "_busy"},     {15'd0, bus.o_busy}, 16'h0000);
    endtask

    // Full transaction; inject drives a stray 0xAA byte during TX (alone, then together with tx_done).
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb, input bit inject);
        logic [9:0] exp;
        logic [5:0] op;
        op  = opb[5:0];
        exp = alu_ref(a, b, op);
        @(negedge clk); bus.i_rx_data = a;   bus.i_rx_done = 1'b1;
        @(negedge clk); bus.i_rx_data = b;
        @(negedge clk); bus.i_rx_data = opb;
        @(negedge clk); bus.i_rx_done = 1'b0;
        chk("compute_busy",     {15'd0, bus.o_busy}, 16'h0001);
        chk("compute_no_start", {15'd0, bus.o_tx_start}, 16'h0000);
        chk("data_a",           {8'h00, bus.o_data_a}, {8'h00, a});
        chk("data_b",           {8'h00, bus.o_data_b}, {8'h00, b});
        chk("opcode",           {10'd0, bus.o_operation_code}, {10'd0, op});
        @(negedge clk);
        chk("res_start",        {15'd0, bus.o_tx_start}, 16'h0001);
        chk("res_byte",         {8'h00, bus.o_tx_data}, {8'h00, exp[7:0]});
        if (inject) begin bus.i_rx_data = 8'hAA; bus.i_rx_done = 1'b1; end
        @(negedge clk);
        bus.i_rx_done = 1'b0;
        chk("res_start_pulse",  {15'd0, bus.o_tx_start}, 16'h0000);
        chk("res_held",         {8'h00, bus.o_tx_data}, {8'h00, exp[7:0]});
        bus.i_tx_done = 1'b1;
        if (inject) begin bus.i_rx_data = 8'hAA; bus.i_rx_done = 1'b1; end
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        bus.i_rx_done = 1'b0;
`ifdef ALU_IF_FLAGS_EN
        chk("flg_start",        {15'd0, bus.o_tx_start}, 16'h0001);
        chk("flg_byte",         {8'h00, bus.o_tx_data}, {14'd0, exp[8], exp[9]});
        chk("flg_busy",         {15'd0, bus.o_busy}, 16'h0001);
        @(negedge clk); bus.i_tx_done = 1'b1;
        @(negedge clk); bus.i_tx_done = 1'b0;
`endif
        chk("idle_busy",        {15'd0, bus.o_busy}, 16'h0000);
        chk("idle_start",       {15'd0, bus.o_tx_start}, 16'h0000);
        chk("a_after_txn",      {8'h00, bus.o_data_a}, {8'h00, a});
    endtask

    initial begin
        logic [5:0] op_tab [8];
        logic [7:0] ra, rb, rop;
        n_cmp = 0;
        n_mis = 0;
        op_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};
        bus.i_rx_data = 8'h00;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_all_zero("reset");

        run_txn(8'h05, 8'h03, 8'h20, 1'b0);
        run_txn(8'hFF, 8'h01, 8'h20, 1'b0);
        run_txn(8'hF0, 8'h3C, 8'hE4, 1'b0);
        repeat (3) @(negedge clk);
        chk("hold_opcode", {10'd0, bus.o_operation_code}, 16'h0024);
        chk("hold_a",      {8'h00, bus.o_data_a}, 16'h00F0);
        chk("hold_tx",     {8'h00, bus.o_tx_data}, 16'h0030);

        run_txn(8'h10, 8'h20, 8'h25, 1'b1);
        run_txn(8'h01, 8'h01, 8'h22, 1'b0);

        // Reset after A and B only.
        @(negedge clk); bus.i_rx_data = 8'h11; bus.i_rx_done = 1'b1;
        @(negedge clk); bus.i_rx_data = 8'h22;
        @(negedge clk); bus.i_rx_done = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_all_zero("mid_reset");
        run_txn(8'h02, 8'h02, 8'h26, 1'b0);

        // Reset while in COMPUTE must kill the pending start pulse.
        @(negedge clk); bus.i_rx_data = 8'h07; bus.i_rx_done = 1'b1;
        @(negedge clk); bus.i_rx_data = 8'h08;
        @(negedge clk); bus.i_rx_data = 8'h20;
        @(negedge clk); bus.i_rx_done = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_all_zero("compute_reset");
        @(negedge clk);
        chk("compute_reset_nostart", {15'd0, bus.o_tx_start}, 16'h0000);

        // Stray tx_done in WAIT_A.
        bus.i_tx_done = 1'b1;
        @(negedge clk); bus.i_tx_done = 1'b0;
        chk("stray_txdone_start", {15'd0, bus.o_tx_start}, 16'h0000);
        chk("stray_txdone_busy",  {15'd0, bus.o_busy}, 16'h0000);
        @(negedge clk);
        chk("stray_txdone_start2", {15'd0, bus.o_tx_start}, 16'h0000);
        run_txn(8'h77, 8'h10, 8'h25, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rop = {2'($urandom_range(0, 3)), op_tab[$urandom_range(0, 7)]};
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                bus.i_tx_done = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            bus.i_tx_done = 1'b0;
            run_txn(ra, rb, rop, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
